mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the two requester ports (instruction fetch and
// data), the shared response bus and the single downstream memory port of the
// arbiter.
//
// Signal groups:
//   Fetch requester : IReq, IAdr -> IGnt, IRValid
//   Data requester  : DReq, DWrite, DByteEn, DAdr, DWData -> DGnt, DRValid
//   Shared response : RData, Err, Stall
//   Memory port     : MemReq, MemWrite, MemByteEn, MemAdr, MemWriteData
//                     <- MemReady, MemRValid, MemReadData
//
// Modports:
//   slave  : the arbiter's view. Requester and memory-response signals are
//            inputs. Grants, responses and the memory request are outputs.
//   master : the environment's view (requesters plus memory), mirrored.
interface mem_port_arbiter_if #(
  parameter int unsigned BIT_COUNT = 32
);
  // Fetch requester
  logic                 IReq;
  logic [BIT_COUNT-1:0] IAdr;
  logic                 IGnt;
  logic                 IRValid;

  // Data requester
  logic                 DReq;
  logic                 DWrite;
  logic [3:0]           DByteEn;
  logic [BIT_COUNT-1:0] DAdr;
  logic [31:0]          DWData;
  logic                 DGnt;
  logic                 DRValid;

  // Shared response / status
  logic [31:0]          RData;
  logic                 Err;
  logic                 Stall;

  // Memory port
  logic                 MemReq;
  logic                 MemWrite;
  logic [3:0]           MemByteEn;
  logic [BIT_COUNT-1:0] MemAdr;
  logic [31:0]          MemWriteData;
  logic                 MemReady;
  logic                 MemRValid;
  logic [31:0]          MemReadData;

  modport slave (
    input  IReq, IAdr,
    input  DReq, DWrite, DByteEn, DAdr, DWData,
    input  MemReady, MemRValid, MemReadData,
    output IGnt, IRValid, DGnt, DRValid,
    output RData, Err, Stall,
    output MemReq, MemWrite, MemByteEn, MemAdr, MemWriteData
  );

  modport master (
    output IReq, IAdr,
    output DReq, DWrite, DByteEn, DAdr, DWData,
    output MemReady, MemRValid, MemReadData,
    input  IGnt, IRValid, DGnt, DRValid,
    input  RData, Err, Stall,
    input  MemReq, MemWrite, MemByteEn, MemAdr, MemWriteData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data requester. At most one memory transaction is
// outstanding at any time.
//
// Operation:
//   IDLE : if any request is pending, a winner is picked and its Gnt is
//          pulsed. Its address, write flag, byte enables, write data and
//          ownership are registered.
//   REQ  : MemReq is driven from the registered request until MemReady.
//   RESP : waits for MemRValid, which is also the acknowledge for writes.
//          The owner's RValid pulses the same cycle with the memory data.
//          If no response arrives within TIMEOUT cycles, the owner's RValid
//          pulses with Err=1 and RData=0.
//
// Ports:
//   clk   : single clock, rising edge.
//   reset : asynchronous, active-high. Abandons any transaction in flight.
//   bus   : mem_port_arbiter_if.slave (requesters, response bus, memory port).
//
// Parameters:
//   BIT_COUNT : address width, 32 or 64.
//   TIMEOUT   : RESP cycles before abort, 1..255.
module mem_port_arbiter #(
  parameter int unsigned BIT_COUNT = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e               state_q, state_d;
  // 1 = data port was granted most recently; resets to 1 so fetch wins the first tie
  logic                 last_data_q, last_data_d;
  // owner of the transaction in flight: 1 = data, 0 = fetch
  logic                 owner_data_q, owner_data_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [BIT_COUNT-1:0] adr_q, adr_d;
  logic                 write_q, write_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;

  logic                 pick_data;
  logic                 grant;
  logic                 rvalid;
  logic                 err;
  logic [31:0]          rdata;

  // Data wins when it is the only requester, or on a tie when fetch was last granted.
  assign pick_data = bus.DReq & (~bus.IReq | ~last_data_q);

  always_comb begin
    state_d      = state_q;
    last_data_d  = last_data_q;
    owner_data_d = owner_data_q;
    cnt_d        = cnt_q;
    adr_d        = adr_q;
    write_d      = write_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    grant        = 1'b0;
    rvalid       = 1'b0;
    err          = 1'b0;
    rdata        = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (bus.IReq || bus.DReq) begin
          grant        = 1'b1;
          owner_data_d = pick_data;
          last_data_d  = pick_data;
          if (pick_data) begin
            adr_d   = bus.DAdr;
            write_d = bus.DWrite;
            be_d    = bus.DByteEn;
            wdata_d = bus.DWData;
          end else begin
            adr_d   = bus.IAdr;
            write_d = 1'b0;
            be_d    = 4'h0;
            wdata_d = 32'h0;
          end
          state_d = StReq;
        end
      end

      StReq: begin
        // Mem* outputs come straight from the registers, so they hold while MemReady is low.
        if (bus.MemReady) begin
          cnt_d   = 8'h0;
          state_d = StResp;
        end
      end

      StResp: begin
        // A response arriving in the abort cycle is delivered as a normal response.
        if (bus.MemRValid) begin
          rvalid  = 1'b1;
          rdata   = bus.MemReadData;
          state_d = StIdle;
        end else if (cnt_q == TimeoutCnt) begin
          rvalid  = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_data_q  <= 1'b1;
      owner_data_q <= 1'b0;
      cnt_q        <= 8'h0;
      adr_q        <= '0;
      write_q      <= 1'b0;
      be_q         <= 4'h0;
      wdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_data_q  <= last_data_d;
      owner_data_q <= owner_data_d;
      cnt_q        <= cnt_d;
      adr_q        <= adr_d;
      write_q      <= write_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
    end
  end

  // Grants are combinational from IDLE, so they are masked while reset is held.
  assign bus.IGnt         = grant & ~pick_data & ~reset;
  assign bus.DGnt         = grant & pick_data & ~reset;
  assign bus.IRValid      = rvalid & ~owner_data_q;
  assign bus.DRValid      = rvalid & owner_data_q;
  assign bus.Err          = err;
  assign bus.RData        = rdata;
  assign bus.Stall        = (state_q != StIdle) | bus.IReq | bus.DReq;

  assign bus.MemReq       = (state_q == StReq);
  assign bus.MemWrite     = write_q;
  assign bus.MemByteEn    = be_q;
  assign bus.MemAdr       = adr_q;
  assign bus.MemWriteData = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The reference model works per
// transaction. It tracks which requesters are pending, the round-robin
// "last granted" bit and the expected grant, accept, response and timeout
// cycles, which follow from the chosen MemReady delay and response latency.
module tb_mem_port_arbiter;

  localparam int unsigned BW    = 32;
  localparam int unsigned TMO   = 4;
  localparam int          NEVER = 99;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.BIT_COUNT(BW)) bus ();

  mem_port_arbiter #(
    .BIT_COUNT(BW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit last_d;   // 1 = data granted most recently
  bit i_pend;
  bit d_pend;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    bus.IReq = 1'b0;
    bus.DReq = 1'b0;
    for (int c = 0; c < n; c++) begin
      bus.MemRValid   = 1'($urandom_range(0, 1));
      bus.MemReady    = 1'($urandom_range(0, 1));
      bus.MemReadData = $urandom;
      sample();
      check("idle_stall", bus.Stall, 1'b0);
      check("idle_memreq", bus.MemReq, 1'b0);
      check("idle_gnt", {bus.IGnt, bus.DGnt}, 2'b00);
      check("idle_rvalid", {bus.IRValid, bus.DRValid, bus.Err}, 3'b000);
      next_cycle();
    end
  endtask

  // One full transaction starting in an IDLE cycle. A new_* request is
  // raised (with fresh fields) only if that requester is not already pending.
  task automatic do_txn(input bit new_i, input bit new_d, input logic [31:0] iadr,
                        input logic [31:0] dadr, input bit dwrite, input logic [3:0] dbe,
                        input logic [31:0] dwdata, input int rdy_delay, input int lat,
                        input logic [31:0] rdata, input bit drop);
    bit          win_d;
    bit          done;
    bit          resp;
    bit          tmo;
    logic [31:0] e_adr;
    bit          e_w;
    logic [3:0]  e_be;
    logic [31:0] e_wd;

    if (!i_pend && !d_pend && !new_i && !new_d) new_i = 1'b1;
    if (new_i && !i_pend) begin
      bus.IAdr = iadr;
      i_pend   = 1'b1;
    end
    if (new_d && !d_pend) begin
      bus.DAdr    = dadr;
      bus.DWrite  = dwrite;
      bus.DByteEn = dbe;
      bus.DWData  = dwdata;
      d_pend      = 1'b1;
    end
    bus.IReq = i_pend;
    bus.DReq = d_pend;

    win_d  = (i_pend && d_pend) ? !last_d : d_pend;
    last_d = win_d;
    e_adr  = win_d ? bus.DAdr : bus.IAdr;
    e_w    = win_d ? bus.DWrite : 1'b0;
    e_be   = bus.DByteEn;
    e_wd   = bus.DWData;

    // grant cycle; stray memory signals in IDLE must have no effect
    bus.MemReady    = 1'($urandom_range(0, 1));
    bus.MemRValid   = 1'($urandom_range(0, 1));
    bus.MemReadData = $urandom;
    sample();
    check("gnt_i", bus.IGnt, !win_d);
    check("gnt_d", bus.DGnt, win_d);
    check("gnt_memreq", bus.MemReq, 1'b0);
    check("gnt_rvalid", {bus.IRValid, bus.DRValid, bus.Err}, 3'b000);
    check("gnt_stall", bus.Stall, 1'b1);
    next_cycle();

    if (drop) begin
      if (win_d) bus.DReq = 1'b0;
      else bus.IReq = 1'b0;
    end

    for (int c = 0; c <= rdy_delay; c++) begin
      bus.MemReady    = (c == rdy_delay);
      bus.MemRValid   = 1'($urandom_range(0, 1));
      bus.MemReadData = $urandom;
      sample();
      check("req_memreq", bus.MemReq, 1'b1);
      check("req_adr", bus.MemAdr, e_adr);
      check("req_write", bus.MemWrite, e_w);
      if (win_d) begin
        check("req_be", bus.MemByteEn, e_be);
        check("req_wdata", bus.MemWriteData, e_wd);
      end
      check("req_quiet", {bus.IGnt, bus.DGnt, bus.IRValid, bus.DRValid, bus.Err}, 5'b0);
      check("req_stall", bus.Stall, 1'b1);
      next_cycle();
    end

    done = 1'b0;
    for (int k = 0; k <= int'(TMO) && !done; k++) begin
      resp            = (k == lat);
      tmo             = !resp && (k == int'(TMO));
      bus.MemReady    = 1'($urandom_range(0, 1));
      bus.MemRValid   = resp;
      bus.MemReadData = resp ? rdata : $urandom;
      sample();
      check("resp_memreq", bus.MemReq, 1'b0);
      check("resp_stall", bus.Stall, 1'b1);
      check("resp_gnt", {bus.IGnt, bus.DGnt}, 2'b00);
      if (resp || tmo) begin
        check("rvalid_i", bus.IRValid, !win_d);
        check("rvalid_d", bus.DRValid, win_d);
        check("resp_err", bus.Err, tmo);
        if (tmo) check("tmo_rdata", bus.RData, 32'h0);
        else if (!e_w) check("resp_rdata", bus.RData, rdata);
        done = 1'b1;
      end else begin
        check("resp_wait", {bus.IRValid, bus.DRValid, bus.Err}, 3'b000);
      end
      next_cycle();
    end
    if (!done) check("resp_never_ended", 1'b0, 1'b1);

    // the owner drops its request once served; the loser keeps waiting
    if (win_d) begin
      d_pend   = 1'b0;
      bus.DReq = 1'b0;
    end else begin
      i_pend   = 1'b0;
      bus.IReq = 1'b0;
    end
    bus.IReq      = i_pend;
    bus.DReq      = d_pend;
    bus.MemRValid = 1'b0;
    bus.MemReady  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ni, nd, w, dr;
    int rd, lt;

    reset           = 1'b1;
    bus.IReq        = 1'b0;
    bus.IAdr        = '0;
    bus.DReq        = 1'b0;
    bus.DWrite      = 1'b0;
    bus.DByteEn     = 4'h0;
    bus.DAdr        = '0;
    bus.DWData      = 32'h0;
    bus.MemReady    = 1'b0;
    bus.MemRValid   = 1'b0;
    bus.MemReadData = 32'h0;
    last_d          = 1'b1;
    i_pend          = 1'b0;
    d_pend          = 1'b0;

    // reset state
    sample();
    check("rst_outs", {bus.IGnt, bus.DGnt, bus.IRValid, bus.DRValid, bus.Err, bus.MemReq,
                       bus.MemWrite}, 7'b0);
    check("rst_memadr", bus.MemAdr, 0);
    check("rst_rdata", bus.RData, 0);
    check("rst_stall_lo", bus.Stall, 1'b0);
    next_cycle();
    bus.IReq = 1'b1;
    sample();
    check("rst_gnt_masked", bus.IGnt, 1'b0);
    check("rst_stall_hi", bus.Stall, 1'b1);
    next_cycle();
    bus.IReq = 1'b0;
    reset    = 1'b0;

    // fetch only, immediate accept, response one cycle after accept
    do_txn(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    // MemReady held low for 5 cycles during a data write
    do_txn(0, 1, 0, 32'h2000, 1, 4'b1010, 32'h12345678, 5, 2, 32'h0, 0);
    idle_gap(2);
    // response never comes: timeout abort, then normal service
    do_txn(1, 0, 32'h300, 0, 0, 0, 0, 0, NEVER, 32'h0, 0);
    do_txn(1, 0, 32'h304, 0, 0, 0, 0, 1, 1, 32'hA5A5A5A5, 0);
    // data requester drops DReq right after DGnt
    do_txn(0, 1, 0, 32'h4000, 0, 4'hF, 0, 1, 1, 32'h0BADF00D, 1);

    // reset while in RESP, late MemRValid afterwards
    bus.IAdr = 32'h500;
    bus.IReq = 1'b1;
    sample();
    check("r42_gnt", bus.IGnt, 1'b1);
    next_cycle();
    bus.MemReady = 1'b1;
    sample();
    check("r42_memreq", bus.MemReq, 1'b1);
    next_cycle();
    bus.MemReady = 1'b0;
    sample();
    check("r42_resp_wait", bus.IRValid, 1'b0);
    next_cycle();
    reset    = 1'b1;
    bus.IReq = 1'b0;
    sample();
    check("r42_rst_outs", {bus.IRValid, bus.DRValid, bus.Err, bus.MemReq, bus.Stall}, 5'b0);
    check("r42_rst_adr", bus.MemAdr, 0);
    next_cycle();
    reset           = 1'b0;
    last_d          = 1'b1;
    bus.MemRValid   = 1'b1;
    bus.MemReadData = 32'hFFFF0000;
    sample();
    check("r42_late_rvalid", {bus.IRValid, bus.DRValid, bus.Err}, 3'b000);
    check("r42_idle", {bus.MemReq, bus.Stall}, 2'b00);
    check("r42_adr", bus.MemAdr, 0);
    next_cycle();
    bus.MemRValid = 1'b0;
    next_cycle();

    // both requesting from reset: fetch first, then data write, then alternation
    reset       = 1'b1;
    bus.IAdr    = 32'h600;
    bus.DAdr    = 32'h700;
    bus.DWrite  = 1'b1;
    bus.DByteEn = 4'b0011;
    bus.DWData  = 32'hCAFEF00D;
    bus.IReq    = 1'b1;
    bus.DReq    = 1'b1;
    i_pend      = 1'b1;
    d_pend      = 1'b1;
    last_d      = 1'b1;
    next_cycle();
    reset = 1'b0;
    do_txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111, 0);
    do_txn(1, 0, 32'h604, 0, 0, 0, 0, 0, 1, 32'h22222222, 0);
    do_txn(0, 1, 0, 32'h704, 1, 4'b0011, 32'h33, 0, 0, 32'h0, 0);
    do_txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44444444, 0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      ni = 1'($urandom_range(0, 1));
      nd = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) == 0);
      rd = $urandom_range(0, 3);
      lt = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TMO - 1));
      if (!i_pend && !d_pend && $urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
      do_txn(ni, nd, $urandom, $urandom, w, 4'($urandom), $urandom, rd, lt, $urandom, dr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
